bit_serializer: RTL and testbench

Parallel-to-serial front end that feeds the serial pattern detector.
- Accepts WIDTH-bit words through a valid/ready handshake.
- Shifts each word out MSB-first, one bit per clock, on a single-bit line with a qualifying valid.
- Consecutive words stream with no idle gap.
- Provides frame markers so downstream logic can align detections to word boundaries.

---
 rtl/bit_serializer.sv | 136 +++++++++++++
 tb/tb_bit_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - MSB-first parallel-to-serial shifter with frame markers
// Optional parity bit per word when SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
   parameter int WIDTH      = 8,
   parameter bit IDLE_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef SERIALIZER_PARITY_EN
      , S_PARITY = 2'd2
`endif
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             ready_dec;
   logic             accept;
`ifdef SERIALIZER_PARITY_EN
   logic             par;
`endif

   // in_ready is a pure state decode, gated only by reset
   assign in_ready = ready_dec && !reset;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (in_valid) next_state = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt == '0) begin
`ifdef SERIALIZER_PARITY_EN
               next_state = S_PARITY;
`else
               next_state = in_valid ? S_SHIFT : S_IDLE;
`endif
            end
         end
`ifdef SERIALIZER_PARITY_EN
         S_PARITY: begin
            next_state = in_valid ? S_SHIFT : S_IDLE;
         end
`endif
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      ser_out     = IDLE_LEVEL;
      ser_valid   = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      busy        = 1'b0;
      ready_dec   = 1'b0;
      case (state)
         S_IDLE: begin
            ready_dec = 1'b1;
         end
         S_SHIFT: begin
            ser_out     = shreg[WIDTH-1];
            ser_valid   = 1'b1;
            busy        = 1'b1;
            frame_start = (cnt == CNT_LAST);
`ifndef SERIALIZER_PARITY_EN
            frame_end   = (cnt == '0);
            ready_dec   = (cnt == '0);
`endif
         end
`ifdef SERIALIZER_PARITY_EN
         S_PARITY: begin
            ser_out   = par;
            ser_valid = 1'b1;
            busy      = 1'b1;
            frame_end = 1'b1;
            ready_dec = 1'b1;
         end
`endif
         default: begin
            ready_dec = 1'b0;
         end
      endcase
   end

   // Datapath: load on accept, otherwise shift while in SHIFT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (accept) begin
         shreg <= in_data;
         cnt   <= CNT_LAST;
      end else if (state == S_SHIFT) begin
         shreg <= shreg << 1;
         if (cnt != '0) cnt <= cnt - CW'(1);
      end
   end

`ifdef SERIALIZER_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par <= 1'b0;
      end else if (accept) begin
         par <= ^in_data;
      end
   end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for bit_serializer
// Accepted words expand into an expected bit list; a negedge monitor pops and compares.
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         ser_out;
   logic         ser_valid;
   logic         frame_start;
   logic         frame_end;
   logic         busy;

   int compared = 0;
   int mismatched = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic b;
      logic fs;
      logic fe;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ser_out     (ser_out),
      .ser_valid   (ser_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a word becomes W bits MSB first, plus an even-parity bit when enabled
   function automatic void push_word(input logic [W-1:0] w);
      exp_t e;
      for (int i = W - 1; i >= 0; i--) begin
         e.b  = w[i];
         e.fs = (i == W - 1);
`ifdef SERIALIZER_PARITY_EN
         e.fe = 1'b0;
`else
         e.fe = (i == 0);
`endif
         exp_q.push_back(e);
      end
`ifdef SERIALIZER_PARITY_EN
      e.b  = ^w;
      e.fs = 1'b0;
      e.fe = 1'b1;
      exp_q.push_back(e);
`endif
   endfunction

   always @(posedge clk) begin
      if (!reset && in_valid && in_ready) push_word(in_data);
   end

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         chk("in_ready", in_ready, (exp_q.size() <= 1));
         chk("busy", busy, (exp_q.size() != 0));
         if (exp_q.size() == 0) begin
            chk("idle_valid", ser_valid, 0);
            chk("idle_level", ser_out, 1);
            chk("idle_fs", frame_start, 0);
            chk("idle_fe", frame_end, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("bit_valid", ser_valid, 1);
            chk("ser_out", ser_out, mon_e.b);
            chk("frame_start", frame_start, mon_e.fs);
            chk("frame_end", frame_end, mon_e.fe);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [W-1:0] w);
      int n;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout: in_ready never rose for word %0h", w);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         in_data = W'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_rst_valid"}, ser_valid, 0);
      chk({tag, "_rst_out"}, ser_out, 1);
      chk({tag, "_rst_busy"}, busy, 0);
      chk({tag, "_rst_ready"}, in_ready, 0);
      chk({tag, "_rst_fs"}, frame_start, 0);
      chk({tag, "_rst_fe"}, frame_end, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $finish;
   end

   initial begin
      int n;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      repeat (3) @(negedge clk);
      #2;
      reset_checks("init");
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      send(8'hA5);
      idle(10);
      send(8'h0F);
      send(8'hF0);
      idle(12);
      idle(5);
      send(8'h01);
      idle(12);
      send(8'hA5);
      send(8'h07);
      idle(12);

      // Abort a frame after three bits; nothing may follow the reset
      send(8'hFF);
      @(negedge clk);
      @(negedge clk);
      #2;
      in_valid = 1'b1;
      reset = 1'b1;
      mon_en = 1'b0;
      #1;
      reset_checks("mid");
      exp_q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      idle(12);

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
         send(W'($urandom));
      end

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         in_valid = 1'b0;
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: %0d expected bits never emitted", exp_q.size());
      end
      idle(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
